// File: rtl/rs_alu_station.sv
// ALU reservation station: captures dispatched entries, wakes sources from the CDB,
// and issues the oldest fully-ready entry to the ALU over a valid/ready handshake.
package rs_pkg;
    localparam int PREG_IDX_WIDTH = 6;

    typedef struct packed {
        logic [1:0]                station_index;
        logic [3:0]                alu_op;
        logic [PREG_IDX_WIDTH-1:0] pd;
        logic [PREG_IDX_WIDTH-1:0] ps1;
        logic                      ps1_valid;
        logic [PREG_IDX_WIDTH-1:0] ps2;
        logic                      ps2_valid;
        logic                      imm_flag;
        logic [31:0]               imm;
        logic [4:0]                rob_idx;
    } reservation_station_entry_t;

    localparam int ENTRY_W = $bits(reservation_station_entry_t);
endpackage

module rs_alu_station
    import rs_pkg::*;
#(
    parameter int         NUM_ENTRIES = 8,
    parameter logic [1:0] STATION_ID  = 2'd0,
    parameter int         AGE_W       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            branch_flush,
    input  logic                            entry_ready,
    input  logic [ENTRY_W-1:0]              dispatched_entry,
    output logic                            entry_received,
    input  logic                            cdb_valid,
    input  logic [PREG_IDX_WIDTH-1:0]       cdb_pd,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [ENTRY_W-1:0]              issue_entry,
    output logic                            full,
    output logic [$clog2(NUM_ENTRIES):0]    count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    reservation_station_entry_t entry_reg [NUM_ENTRIES];
    logic [AGE_W-1:0]           age_reg   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]     valid_reg;

    logic [NUM_ENTRIES-1:0]     ready;
    logic [NUM_ENTRIES-1:0]     wake1;
    logic [NUM_ENTRIES-1:0]     wake2;

    reservation_station_entry_t incoming;
    reservation_station_entry_t insert_entry;
    reservation_station_entry_t selected;
    logic                       cdb_hit;
    logic                       free_found;
    logic [IDX_W-1:0]           free_idx;
    logic                       sel_found;
    logic [IDX_W-1:0]           sel_idx;
    logic [AGE_W-1:0]           sel_age;
    logic [CNT_W-1:0]           count_next;
    logic                       issue_fire;

    assign incoming = dispatched_entry;
    // Physical register 0 is the hardwired x0 mapping and never gets broadcast.
    assign cdb_hit  = cdb_valid && (cdb_pd != '0);

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
            assign ready[gi] = valid_reg[gi] && entry_reg[gi].ps1_valid && entry_reg[gi].ps2_valid;
            assign wake1[gi] = cdb_hit && (entry_reg[gi].ps1 == cdb_pd);
            assign wake2[gi] = cdb_hit && (entry_reg[gi].ps2 == cdb_pd);
        end
    endgenerate

    // Bypass the current broadcast into the entry being captured so no wakeup is lost.
    always_comb begin
        insert_entry           = incoming;
        insert_entry.ps1_valid = incoming.ps1_valid || (incoming.ps1 == '0) ||
                                 (cdb_hit && incoming.ps1 == cdb_pd);
        insert_entry.ps2_valid = incoming.ps2_valid || (incoming.ps2 == '0) ||
                                 (cdb_hit && incoming.ps2 == cdb_pd);
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid_reg[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            count_next = count_next + CNT_W'(valid_reg[i]);
        end
    end

    // Strict greater-than keeps the lowest index on equal (possibly saturated) ages.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready[i] && (!sel_found || age_reg[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_reg[i];
            end
        end
    end

    always_comb begin
        selected           = entry_reg[sel_idx];
        selected.ps1_valid = 1'b1;
        selected.ps2_valid = 1'b1;
    end

    assign full           = &valid_reg;
    assign count          = count_next;
    assign entry_received = entry_ready && (incoming.station_index == STATION_ID) &&
                            !full && !branch_flush && !rst;
    assign issue_valid    = sel_found && !branch_flush && !rst;
    assign issue_entry    = selected;
    assign issue_fire     = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rst || branch_flush) begin
                valid_reg[i] <= 1'b0;
                age_reg[i]   <= '0;
            end else if (issue_fire && sel_idx == IDX_W'(i)) begin
                valid_reg[i] <= 1'b0;
            end else if (valid_reg[i]) begin
                if (age_reg[i] != AGE_MAX) begin
                    age_reg[i] <= age_reg[i] + 1'b1;
                end
                if (wake1[i]) begin
                    entry_reg[i].ps1_valid <= 1'b1;
                end
                if (wake2[i]) begin
                    entry_reg[i].ps2_valid <= 1'b1;
                end
            end else if (entry_received && free_found && free_idx == IDX_W'(i)) begin
                valid_reg[i] <= 1'b1;
                entry_reg[i] <= insert_entry;
                age_reg[i]   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios then random traffic, all checked
// against a timestamp-based slot model evaluated every cycle.
module tb_rs_alu_station;
    import rs_pkg::*;

    localparam int N       = 8;
    localparam int AGE_MAX = 15;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        branch_flush;
    logic                        entry_ready;
    reservation_station_entry_t  din;
    logic                        entry_received;
    logic                        cdb_valid;
    logic [PREG_IDX_WIDTH-1:0]   cdb_pd;
    logic                        issue_valid;
    logic                        issue_ready;
    reservation_station_entry_t  dout;
    logic                        full;
    logic [3:0]                  count;

    always #5 clk = ~clk;

    rs_alu_station #(.NUM_ENTRIES(N), .STATION_ID(2'd0), .AGE_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .branch_flush(branch_flush),
        .entry_ready(entry_ready),
        .dispatched_entry(din),
        .entry_received(entry_received),
        .cdb_valid(cdb_valid),
        .cdb_pd(cdb_pd),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_entry(dout),
        .full(full),
        .count(count)
    );

    // Reference: each occupied slot remembers the cycle it became visible; age is elapsed cycles.
    bit                          m_valid [N];
    reservation_station_entry_t  m_entry [N];
    int                          m_ins   [N];
    int                          cyc;
    int                          checks;
    int                          errors;
    bit                          last_recv;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic reservation_station_entry_t mk(input logic [1:0] si, input int p1, input bit v1,
                                                      input int p2, input bit v2, input bit imm);
        reservation_station_entry_t e;
        e               = '0;
        e.station_index = si;
        e.alu_op        = 4'($urandom);
        e.pd            = PREG_IDX_WIDTH'($urandom);
        e.ps1           = PREG_IDX_WIDTH'(p1);
        e.ps1_valid     = v1;
        e.ps2           = PREG_IDX_WIDTH'(p2);
        e.ps2_valid     = v2;
        e.imm_flag      = imm;
        e.imm           = $urandom;
        e.rob_idx       = 5'($urandom);
        return e;
    endfunction

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic check_cycle();
        int e_count;
        bit e_recv;
        bit e_iv;
        int e_sel;
        int best_age;
        int age;
        int free_slot;
        bit hit;
        reservation_station_entry_t e_ie;
        reservation_station_entry_t ne;
        #2;
        e_count = 0;
        free_slot = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) e_count++;
            else if (free_slot < 0) free_slot = i;
        end
        e_recv = entry_ready && din.station_index == 2'd0 && e_count < N && !branch_flush && !rst;
        e_sel = -1;
        best_age = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_entry[i].ps1_valid && m_entry[i].ps2_valid) begin
                age = cyc - m_ins[i];
                if (age > AGE_MAX) age = AGE_MAX;
                if (age > best_age) begin
                    best_age = age;
                    e_sel = i;
                end
            end
        end
        e_iv = (e_sel >= 0) && !branch_flush && !rst;
        chk("count", count, e_count);
        chk("full", full, e_count == N);
        chk("entry_received", entry_received, e_recv);
        chk("issue_valid", issue_valid, e_iv);
        if (e_iv) begin
            e_ie = m_entry[e_sel];
            e_ie.ps1_valid = 1'b1;
            e_ie.ps2_valid = 1'b1;
            chk("issue_entry", dout, e_ie);
        end
        hit = cdb_valid && cdb_pd != 0;
        if (rst || branch_flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else begin
            if (e_iv && issue_ready) m_valid[e_sel] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && hit && m_entry[i].ps1 == cdb_pd) m_entry[i].ps1_valid = 1'b1;
                if (m_valid[i] && hit && m_entry[i].ps2 == cdb_pd) m_entry[i].ps2_valid = 1'b1;
            end
            if (e_recv) begin
                ne = din;
                if (ne.ps1 == 0 || (hit && ne.ps1 == cdb_pd)) ne.ps1_valid = 1'b1;
                if (ne.ps2 == 0 || (hit && ne.ps2 == cdb_pd)) ne.ps2_valid = 1'b1;
                m_valid[free_slot] = 1'b1;
                m_entry[free_slot] = ne;
                m_ins[free_slot]   = cyc + 1;
            end
        end
        last_recv = e_recv;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input reservation_station_entry_t e);
        din = e;
        entry_ready = 1'b1;
        for (int k = 0; k < 12 && entry_ready; k++) begin
            check_cycle();
            if (last_recv) entry_ready = 1'b0;
        end
        entry_ready = 1'b0;
    endtask

    initial begin
        int hold;
        checks = 0; errors = 0; cyc = 0; last_recv = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ins[i] = 0;
            m_entry[i] = '0;
        end
        rst = 1'b1; branch_flush = 1'b0; entry_ready = 1'b0; din = '0;
        cdb_valid = 1'b0; cdb_pd = '0; issue_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cycle();
        rst = 1'b0;
        #1 chk("reset_count", count, 0);
        chk("reset_issue_valid", issue_valid, 0);

        // Ready-on-insert entry issues the cycle after capture.
        send(mk(2'd0, 5, 1, 0, 0, 1));
        chk("s1_count", count, 1);
        chk("s1_issue_valid", issue_valid, 1);
        issue_ready = 1'b1;
        check_cycle();
        issue_ready = 1'b0;
        chk("s1_drain", count, 0);
        check_cycle();

        // CDB wakeup after insert, then bypass wakeup on the insert cycle.
        send(mk(2'd0, 7, 0, 0, 0, 0));
        repeat (3) check_cycle();
        cdb_valid = 1'b1; cdb_pd = 6'd7;
        check_cycle();
        cdb_valid = 1'b0;
        chk("s2_woken", issue_valid, 1);
        issue_ready = 1'b1;
        check_cycle();
        issue_ready = 1'b0;
        din = mk(2'd0, 7, 0, 0, 0, 0);
        entry_ready = 1'b1; cdb_valid = 1'b1; cdb_pd = 6'd7;
        check_cycle();
        entry_ready = 1'b0; cdb_valid = 1'b0;
        chk("s2_bypass", issue_valid, 1);
        issue_ready = 1'b1;
        check_cycle();
        issue_ready = 1'b0;

        // Foreign station index is never acknowledged.
        din = mk(2'd2, 1, 1, 2, 1, 0);
        entry_ready = 1'b1;
        repeat (5) check_cycle();
        entry_ready = 1'b0;
        chk("s3_count", count, 0);

        // Fill all slots; the ninth waits until an issue frees a slot.
        for (int i = 0; i < N; i++) send(mk(2'd0, 10 + i, 0, 0, 0, 0));
        chk("s4_full", full, 1);
        din = mk(2'd0, 30, 0, 0, 0, 0);
        entry_ready = 1'b1;
        repeat (3) check_cycle();
        cdb_valid = 1'b1; cdb_pd = 6'd10;
        check_cycle();
        cdb_valid = 1'b0; issue_ready = 1'b1;
        check_cycle();
        issue_ready = 1'b0;
        chk("s4_count7", count, 7);
        chk("s4_not_full", full, 0);
        check_cycle();
        if (last_recv) entry_ready = 1'b0;
        chk("s4_ninth", count, 8);
        entry_ready = 1'b0;

        // Flush with a ready slot and a concurrent broadcast.
        cdb_valid = 1'b1; cdb_pd = 6'd11;
        check_cycle();
        branch_flush = 1'b1; cdb_pd = 6'd12;
        check_cycle();
        branch_flush = 1'b0; cdb_valid = 1'b0;
        chk("s6_count", count, 0);
        repeat (3) check_cycle();

        // Older woken entry beats a younger one that was ready earlier.
        send(mk(2'd0, 20, 0, 0, 0, 0));
        send(mk(2'd0, 21, 1, 0, 0, 0));
        cdb_valid = 1'b1; cdb_pd = 6'd20;
        check_cycle();
        cdb_valid = 1'b0;
        repeat (2) check_cycle();
        issue_ready = 1'b1;
        #1 chk("s5_first", dout.ps1, 20);
        check_cycle();
        #1 chk("s5_second", dout.ps1, 21);
        check_cycle();
        issue_ready = 1'b0;

        // Random traffic.
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!entry_ready && $urandom_range(0, 1) == 1) begin
                din = mk(($urandom_range(0, 9) == 0) ? 2'd2 : 2'd0,
                         $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                         $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1);
                entry_ready = 1'b1;
                hold = 0;
            end
            cdb_valid    = $urandom_range(0, 2) == 0;
            cdb_pd       = PREG_IDX_WIDTH'($urandom_range(0, 7));
            issue_ready  = $urandom_range(0, 2) != 0;
            branch_flush = $urandom_range(0, 60) == 0;
            rst          = $urandom_range(0, 250) == 0;
            check_cycle();
            hold++;
            if (last_recv || (din.station_index != 2'd0 && hold > 3)) entry_ready = 1'b0;
        end
        rst = 1'b0; branch_flush = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0; entry_ready = 1'b0;
        check_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
